// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
// Shared constants and elaboration helpers for the mod_counter family.
//   DIR_UP / DIR_DOWN    : encodings of the 'up' input
//   MODE_WRAP / MODE_SAT : encodings of the 'sat' input
//   clog2()              : sizes the prescaler phase register
//   width_ok()           : checks 1 <= MAX <= 2^WIDTH-1 and WIDTH >= 2
package mod_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit width_ok(input int width, input longint maxv);
        if (width < 2 || maxv < 1) return 1'b0;
        if (width >= 63) return 1'b1;
        return maxv < (longint'(1) << width);
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// mod_counter_prescaler
// Divides enabled cycles by PRESCALE. The phase advances on every cycle with
// en=1 and wraps to 0 after PRESCALE-1; tick is asserted on the enabled cycle
// that sits on the terminal phase. en=0 freezes the phase.
// Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset, clears the phase
//   en    in  enabled cycle (count enable and no load)
//   clr   in  synchronous phase clear (used for load)
//   tick  out step strobe for the counter (combinational from phase and en)
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter
// Parametrised modulo up/down counter with synchronous load, wrap/saturate
// boundary mode, registered terminal-count pulse and sticky overflow flag.
// Optional step prescaler is built only when MOD_COUNTER_PRESCALE_EN is defined.
// Parameters: WIDTH (>=2), MAX (1..2^WIDTH-1), PRESCALE (>=1, prescaler only)
// Ports:
//   clk     in  rising-edge clock
//   reset   in  synchronous active-high reset (cnt, tc, ovf, prescaler phase)
//   en      in  count enable
//   up      in  1 = increment, 0 = decrement
//   load    in  synchronous load of din (clamped to MAX)
//   din     in  load value
//   sat     in  1 = saturate at the boundary, 0 = wrap
//   clr_ovf in  clear sticky overflow flag (a boundary event in the same cycle wins)
//   cnt     out current count
//   tc      out one-cycle pulse after each boundary event
//   ovf     out sticky boundary flag
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    generate
        if (!width_ok(WIDTH, MAX) || PRESCALE < 1) begin : g_param_check
            $fatal(1, "mod_counter: illegal WIDTH/MAX/PRESCALE combination");
        end
    endgenerate

    // Load values above the terminal value are clamped so cnt never leaves 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        return (value > MAX_V) ? MAX_V : value;
    endfunction

    // Next count for a step; holds at the boundary in saturate mode.
    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic dir,
                                                    input logic mode);
        logic [WIDTH-1:0] r;
        r = cur;
        if (dir == DIR_UP) begin
            if (cur < MAX_V) r = cur + WIDTH'(1);
            else if (mode == MODE_WRAP) r = '0;
        end else begin
            if (cur != '0) r = cur - WIDTH'(1);
            else if (mode == MODE_WRAP) r = MAX_V;
        end
        return r;
    endfunction

    logic             tick;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] cnt_next;

`ifdef MOD_COUNTER_PRESCALE_EN
    // Load discards the pending phase so the step spacing restarts from the load.
    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en && !load),
        .clr   (load),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step     = en && !load && tick;
    assign boundary = step && ((up == DIR_UP) ? (cnt == MAX_V) : (cnt == '0));

    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = clamp_load(din);
        end else if (step) begin
            cnt_next = step_value(cnt, up, sat);
        end
    end

    // Count, terminal-count and overflow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            tc  <= boundary;
            if (boundary) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
